maze_generator: RTL and testbench
=================================

# maze_generator

Builds a random perfect maze (exactly one path between any two open cells) in the same grid format that the maze solver consumes, so the solver can be driven by fresh mazes without a testbench-supplied array. The generator sits upstream of the solver and drives its `maze` input directly. It uses the binary-tree carving algorithm, seeded by a 16-bit LFSR. It carves one cell per clock and raises `done` when the grid is stable.

## Interface
- `SIZE`, default 9: grid edge length. Must be odd and ≥5.
- `C`, localparam, value (SIZE-1)/2: number of cells per side.
- `N`, localparam, value $clog2(SIZE): coordinate width.
- `DEFAULT_SEED`, default 16'hACE1: seed used whenever the loaded seed is 0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle request. Sampled only in IDLE or DONE.
- `seed` in 16: LFSR seed, captured on an accepted `start`.
- `busy` out 1: high in FILL, CARVE and OPEN.
- `done` out 1: high in DONE. Held until the next accepted `start` or reset.
- `maze` out [SIZE-1:0] × SIZE, unpacked `maze[row][col]`: 1 = wall, 0 = open. Bit index is the column.

## Operation
- Cell (i,j), with i,j in 0..C-1, lives at `maze[2i+1][2j+1]`.
  - Its north wall is `maze[2i][2j+1]`.
  - Its west wall is `maze[2i+1][2j]`.
- States:
  - IDLE: on `start`, load LFSR with `seed`, or with DEFAULT_SEED if `seed`==0. Set r=0 and go to FILL.
  - FILL: write `maze[r]` to all ones. Increment r each cycle. After r=SIZE-1, set i=j=0 and go to CARVE.
  - CARVE: each cycle, clear the cell bit of (i,j), then:
    - i=0, j=0: no extra carve.
    - i=0, j>0: clear the west wall.
    - i>0, j=0: clear the north wall.
    - otherwise: if `lfsr[0]`=1, clear the north wall; else clear the west wall.
    - After the cell, advance the LFSR one step. Order is row-major: j increments, wraps to 0 and i increments. After (C-1,C-1), go to OPEN.
  - OPEN: clear `maze[0][1]` (entry) and `maze[SIZE-1][SIZE-2]` (exit). Go to DONE.
  - DONE: `done`=1. An accepted `start` behaves as in IDLE, and `done` falls on that same edge.
- LFSR: 16-bit Galois, mask 16'hB400 (x^16+x^14+x^13+x^11+1), shift right, feedback from bit 0.
- `start` in FILL, CARVE or OPEN is ignored.
- Invariant at DONE:
  - Exactly C² + (C²−1) + 2 zeros in the grid; for SIZE=9 that is 33.
  - All even/even positions are 1.
  - All border bits are 1 except the entry and exit.

## Timing
- Reset values:
  - state IDLE
  - `maze` all ones
  - `busy`=0, `done`=0
  - LFSR=DEFAULT_SEED
  - r=i=j=0
- Outputs are registered. `maze` changes only in FILL, CARVE and OPEN.
- Latency: `done` rises on the (SIZE + C² + 1)th rising edge after the edge that accepts `start`; for SIZE=9 that is the 26th. `busy` rises on the accepting edge and falls on the same edge that `done` rises.
- Reset mid-operation immediately restores all reset values, including an all-ones maze.
- A consumer must hold off its own reset until `done`=1. `maze` is stable for as long as `done`=1.

## Structure
- Shared package `maze_pkg` holds:
  - the generator state enum;
  - WALL/OPEN bit constants;
  - LFSR mask 16'hB400 and DEFAULT_SEED;
  - direction encodings RIGHT=0, LEFT=1, DOWN=2, UP=3, NONE=4, shared with the solver.
- One sub-module, `maze_lfsr16`:
  - ports clk, rst, load, seed, step, q[15:0];
  - applies the zero-seed substitution internally.

## Test plan
- Reset, then idle 5 cycles → `busy`=0, `done`=0, every `maze` bit 1, no change.
- `seed`=16'h0001, one-cycle `start`, SIZE=9 → `busy` high for exactly 26 cycles and `done` rises on edge 26. `maze[0][1]`=0, `maze[8][7]`=0, remaining border all 1. All odd/odd bits 0, all even/even bits 1, zero-count 33. BFS from (0,1) reaches (8,7).
- `seed`=0 and `seed`=16'hACE1 → bit-identical mazes. `seed`=16'h0001 vs 16'h1234 → mazes differ in at least one interior wall bit.
- `start` pulsed at cycles 3 and 10 after an accepted start → ignored, `done` still on edge 26. `start` while `done`=1 → `done` falls on that edge and a new maze completes 26 edges later.
- `rst` asserted during CARVE (cycle 15) → on the same cycle `maze` all ones and `busy`=0. A following `start` completes normally and the result matches a clean run with the same seed.
- Drive the solver from the generator output for 20 random seeds, releasing the solver reset at `done` → solver `done`=1 within 4·SIZE² cycles and its final x,y equals (7,8) every time.

Source files
------------

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Types and constants shared by the maze generator and the maze solver:
//   - gen_state_e : generator FSM states
//   - gen_dbg_t   : generator debug view (FSM state and LFSR contents)
//   - WALL / OPEN : grid bit meanings
//   - LFSR_MASK, DEFAULT_SEED_C : LFSR feedback taps and fallback seed
//   - dir_e       : move directions, encoded the same way as in the solver
// -----------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CARVE = 3'd2,
        ST_OPEN  = 3'd3,
        ST_DONE  = 3'd4
    } gen_state_e;

    typedef struct packed {
        gen_state_e  state;
        logic [15:0] lfsr;
    } gen_dbg_t;

    localparam logic WALL = 1'b1;
    localparam logic OPEN = 1'b0;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_MASK      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED_C = 16'hACE1;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        DOWN  = 3'd2,
        UP    = 3'd3,
        NONE  = 3'd4
    } dir_e;

endpackage

// File: rtl/maze_lfsr16.sv
// -----------------------------------------------------------------------------
// maze_lfsr16
// 16-bit Galois LFSR, shifting right with feedback from bit 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (q returns to DEFAULT_SEED)
//   load      : capture seed (a zero seed is replaced by DEFAULT_SEED, since the
//               all-zero state would lock the register)
//   seed[15:0]: value captured on load
//   step      : advance one step (load has priority)
//   q[15:0]   : current register contents
// -----------------------------------------------------------------------------
module maze_lfsr16
    import maze_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= DEFAULT_SEED;
        end else if (load) begin
            q_r <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (step) begin
            q_r <= {1'b0, q_r[15:1]} ^ (q_r[0] ? LFSR_MASK : 16'h0000);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/maze_generator.sv
// -----------------------------------------------------------------------------
// maze_generator
// Builds a random perfect maze with the binary-tree algorithm: every cell
// except the first opens either its north or its west wall, so the open cells
// always form a spanning tree. One cell is carved per clock; the grid is
// presented in the format the maze solver reads.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle request, accepted only in IDLE or DONE
//   seed[15:0]      : LFSR seed captured with an accepted start (0 -> DEFAULT_SEED)
//   busy            : generation in progress (FILL, CARVE, OPEN)
//   done            : maze complete and stable, held until the next start/reset
//   maze[SIZE][SIZE]: maze[row][col], 1 = wall, 0 = open
//   dbg             : FSM state and LFSR contents
//
// Handshake: start is a request without backpressure. It is taken on any edge
// where it is high while busy is low; busy goes high on that same edge and
// start is ignored until busy falls again together with the rise of done.
// -----------------------------------------------------------------------------
module maze_generator
    import maze_pkg::*;
#(
    parameter int          SIZE         = 9,
    parameter logic [15:0] DEFAULT_SEED = DEFAULT_SEED_C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [15:0]     seed,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] maze [SIZE],
    output gen_dbg_t        dbg
);

    localparam int C = (SIZE - 1) / 2;
    localparam int N = $clog2(SIZE);

    localparam logic [N-1:0] LAST_ROW  = N'(SIZE - 1);
    localparam logic [N-1:0] LAST_CELL = N'(C - 1);

    gen_state_e      state_q;
    gen_state_e      state_d;
    logic [N-1:0]    r_q;
    logic [N-1:0]    i_q;
    logic [N-1:0]    j_q;
    logic [SIZE-1:0] maze_q [SIZE];
    logic            busy_q;
    logic            done_q;

    logic            lfsr_load;
    logic            lfsr_step;
    logic [15:0]     lfsr_q;

    // Grid coordinates of the current cell and of its two candidate walls.
    logic [N-1:0]    cell_row;
    logic [N-1:0]    cell_col;
    logic [N-1:0]    north_row;
    logic [N-1:0]    west_col;
    logic            carve_north;
    logic            carve_west;

    maze_lfsr16 #(
        .DEFAULT_SEED(DEFAULT_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .load(lfsr_load),
        .seed(seed),
        .step(lfsr_step),
        .q   (lfsr_q)
    );

    // i, j < C <= 2^(N-1), so 2*i+1 always fits in N bits.
    assign cell_row  = {i_q[N-2:0], 1'b1};
    assign cell_col  = {j_q[N-2:0], 1'b1};
    assign north_row = {i_q[N-2:0], 1'b0};
    assign west_col  = {j_q[N-2:0], 1'b0};

    // Top row can only go west, left column can only go north, the corner
    // cell carves nothing; everywhere else the LFSR picks.
    always_comb begin
        carve_north = 1'b0;
        carve_west  = 1'b0;
        if (i_q == '0 && j_q == '0) begin
            carve_north = 1'b0;
        end else if (i_q == '0) begin
            carve_west = 1'b1;
        end else if (j_q == '0) begin
            carve_north = 1'b1;
        end else if (lfsr_q[0]) begin
            carve_north = 1'b1;
        end else begin
            carve_west = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_FILL;
                    lfsr_load = 1'b1;
                end
            end
            ST_FILL: begin
                if (r_q == LAST_ROW) begin
                    state_d = ST_CARVE;
                end
            end
            ST_CARVE: begin
                lfsr_step = 1'b1;
                if (i_q == LAST_CELL && j_q == LAST_CELL) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: row/cell counters, grid and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int k = 0; k < SIZE; k++) begin
                maze_q[k] <= '1;
            end
        end else begin
            busy_q <= (state_d == ST_FILL) || (state_d == ST_CARVE) || (state_d == ST_OPEN);
            done_q <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_q <= '0;
                    end
                end
                ST_FILL: begin
                    maze_q[r_q] <= '1;
                    if (r_q == LAST_ROW) begin
                        r_q <= '0;
                        i_q <= '0;
                        j_q <= '0;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                ST_CARVE: begin
                    maze_q[cell_row][cell_col] <= OPEN;
                    if (carve_north) begin
                        maze_q[north_row][cell_col] <= OPEN;
                    end
                    if (carve_west) begin
                        maze_q[cell_row][west_col] <= OPEN;
                    end
                    if (j_q == LAST_CELL) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                ST_OPEN: begin
                    maze_q[0][1]           <= OPEN;
                    maze_q[SIZE-1][SIZE-2] <= OPEN;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign maze      = maze_q;
    assign dbg.state = state_q;
    assign dbg.lfsr  = lfsr_q;

endmodule

// File: tb/tb_maze_generator.sv
// -----------------------------------------------------------------------------
// tb_maze_generator
// Directed bench for maze_generator (SIZE = 9): reset state, a hand-derived
// maze for seed 1, model-checked mazes for further seeds, structural
// invariants with a path search, ignored starts, restart from DONE and reset
// in the middle of carving.
// -----------------------------------------------------------------------------
module tb_maze_generator;
    import maze_pkg::*;

    localparam int SIZE   = 9;
    localparam int LAT    = 26;
    localparam int ZEROS  = 33;
    localparam int BUDGET = 100;

    typedef struct packed {
        logic [15:0]             seed;
        logic                    use_model;
        logic [SIZE-1:0][SIZE-1:0] rows;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     seed;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] maze [SIZE];
    gen_dbg_t        dbg;

    int tests = 0;
    int fails = 0;

    logic [SIZE-1:0] exp_q[$];
    logic [SIZE-1:0] got    [SIZE];
    logic [SIZE-1:0] keep_a [SIZE];
    logic [SIZE-1:0] keep_b [SIZE];

    vec_t vecs [5];

    maze_generator #(.SIZE(SIZE)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .seed (seed),
        .busy (busy),
        .done (done),
        .maze (maze),
        .dbg  (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic grab();
        for (int r = 0; r < SIZE; r++) got[r] = maze[r];
    endtask

    // Reference carving straight from the algorithm description.
    task automatic push_model(input logic [15:0] s);
        logic [15:0]     l;
        logic [SIZE-1:0] m [SIZE];
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int r = 0; r < SIZE; r++) m[r] = '1;
        for (int i = 0; i < (SIZE-1)/2; i++) begin
            for (int j = 0; j < (SIZE-1)/2; j++) begin
                m[2*i+1][2*j+1] = 1'b0;
                if (i == 0 && j == 0) begin
                end else if (i == 0) begin
                    m[2*i+1][2*j] = 1'b0;
                end else if (j == 0) begin
                    m[2*i][2*j+1] = 1'b0;
                end else if (l[0]) begin
                    m[2*i][2*j+1] = 1'b0;
                end else begin
                    m[2*i+1][2*j] = 1'b0;
                end
                l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            end
        end
        m[0][1] = 1'b0;
        m[SIZE-1][SIZE-2] = 1'b0;
        for (int r = 0; r < SIZE; r++) exp_q.push_back(m[r]);
    endtask

    task automatic push_vec(input vec_t v);
        if (v.use_model) push_model(v.seed);
        else for (int r = 0; r < SIZE; r++) exp_q.push_back(v.rows[r]);
    endtask

    task automatic check_maze(input string name);
        logic [SIZE-1:0] e;
        grab();
        for (int r = 0; r < SIZE; r++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s expq_empty", name), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s row%0d", name, r), 32'(got[r]), 32'(e));
            end
        end
    endtask

    task automatic check_all_ones(input string name);
        int ones_rows;
        ones_rows = 0;
        for (int r = 0; r < SIZE; r++) if (maze[r] == '1) ones_rows++;
        check(name, ones_rows, SIZE);
    endtask

    // Zero count, wall lattice, border and path from entry to exit.
    task automatic check_invariants(input string name);
        int zeros, bad_even, bad_border, visited, cr, cc, nr, nc;
        bit vis [SIZE][SIZE];
        int qr[$];
        int qc[$];
        zeros = 0; bad_even = 0; bad_border = 0; visited = 0;
        grab();
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                vis[r][c] = 1'b0;
                if (got[r][c] == 1'b0) zeros++;
                if (r % 2 == 0 && c % 2 == 0 && got[r][c] != 1'b1) bad_even++;
                if ((r == 0 || c == 0 || r == SIZE-1 || c == SIZE-1) &&
                    !(r == 0 && c == 1) && !(r == SIZE-1 && c == SIZE-2) &&
                    got[r][c] != 1'b1) bad_border++;
            end
        end
        check($sformatf("%s zeros", name), zeros, ZEROS);
        check($sformatf("%s even_even", name), bad_even, 0);
        check($sformatf("%s border", name), bad_border, 0);
        check($sformatf("%s entry", name), 32'(got[0][1]), 0);
        check($sformatf("%s exit", name), 32'(got[SIZE-1][SIZE-2]), 0);
        if (got[0][1] == 1'b0) begin
            vis[0][1] = 1'b1; qr.push_back(0); qc.push_back(1);
        end
        while (qr.size() > 0) begin
            cr = qr.pop_front(); cc = qc.pop_front(); visited++;
            for (int d = 0; d < 4; d++) begin
                nr = cr + ((d == 2) ? 1 : (d == 3) ? -1 : 0);
                nc = cc + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
                if (nr >= 0 && nr < SIZE && nc >= 0 && nc < SIZE) begin
                    if (!vis[nr][nc] && got[nr][nc] == 1'b0) begin
                        vis[nr][nc] = 1'b1; qr.push_back(nr); qc.push_back(nc);
                    end
                end
            end
        end
        check($sformatf("%s reach_exit", name), 32'(vis[SIZE-1][SIZE-2]), 1);
        check($sformatf("%s reach_all", name), visited, ZEROS);
    endtask

    // ---------------- driver ----------------
    // Accepts s, optionally pulses start on edges pa/pb, then waits for done.
    task automatic run_gen(input logic [15:0] s, input int pa, input int pb, input string name);
        int lat, busy_cnt;
        @(negedge clk);
        seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed = 16'h5555;
        check($sformatf("%s done_low_at_accept", name), 32'(done), 0);
        check($sformatf("%s busy_at_accept", name), 32'(busy), 1);
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        for (int n = 1; n <= BUDGET; n++) begin
            start = (n == pa || n == pb);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (lat < 0) begin
            check($sformatf("%s timeout", name), 32'd0, 32'd1);
        end else begin
            check($sformatf("%s latency", name), lat, LAT);
            check($sformatf("%s busy_cycles", name), busy_cnt, LAT);
            check($sformatf("%s busy_low_at_done", name), 32'(busy), 0);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int diff;
        logic [15:0] rs;

        // Seed 1 worked by hand; others checked against the reference carving.
        vecs[0] = '0; vecs[0].seed = 16'h0001; vecs[0].use_model = 1'b0;
        vecs[0].rows[0] = 9'h1FD; vecs[0].rows[1] = 9'h101; vecs[0].rows[2] = 9'h1FD;
        vecs[0].rows[3] = 9'h101; vecs[0].rows[4] = 9'h17D; vecs[0].rows[5] = 9'h141;
        vecs[0].rows[6] = 9'h1D5; vecs[0].rows[7] = 9'h115; vecs[0].rows[8] = 9'h17F;
        vecs[1] = '0; vecs[1].seed = 16'h1234; vecs[1].use_model = 1'b1;
        vecs[2] = '0; vecs[2].seed = 16'hACE1; vecs[2].use_model = 1'b1;
        vecs[3] = '0; vecs[3].seed = 16'h0000; vecs[3].use_model = 1'b1;
        vecs[4] = '0; vecs[4].seed = 16'hFFFF; vecs[4].use_model = 1'b1;

        rst = 1'b1; start = 1'b0; seed = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Reset state held through 5 idle cycles.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d busy", c), 32'(busy), 0);
            check($sformatf("idle%0d done", c), 32'(done), 0);
            check_all_ones($sformatf("idle%0d all_ones", c));
        end
        check("reset state", 32'(dbg.state), 32'(ST_IDLE));
        check("reset lfsr", 32'(dbg.lfsr), 32'h0000ACE1);

        // Table of seeds.
        for (int v = 0; v < 5; v++) begin
            run_gen(vecs[v].seed, 0, 0, $sformatf("vec%0d", v));
            push_vec(vecs[v]);
            check_maze($sformatf("vec%0d", v));
            check_invariants($sformatf("vec%0d", v));
            if (v == 0) for (int r = 0; r < SIZE; r++) keep_a[r] = got[r];
            if (v == 1) begin
                diff = 0;
                for (int r = 1; r < SIZE-1; r++) if (got[r] != keep_a[r]) diff++;
                check("seed1_vs_1234 differ", 32'(diff != 0), 1);
            end
            if (v == 2) for (int r = 0; r < SIZE; r++) keep_b[r] = got[r];
            if (v == 3) begin
                diff = 0;
                for (int r = 0; r < SIZE; r++) if (got[r] != keep_b[r]) diff++;
                check("seed0_vs_ace1 identical", diff, 0);
            end
        end

        // Maze stays put while done is held.
        repeat (7) @(negedge clk);
        diff = 0;
        for (int r = 0; r < SIZE; r++) if (maze[r] != got[r]) diff++;
        check("stable_in_done", diff, 0);
        check("done_held", 32'(done), 1);

        // Starts during FILL and CARVE are ignored.
        run_gen(16'h0001, 3, 10, "ignored_start");
        push_vec(vecs[0]);
        check_maze("ignored_start");

        // Restart straight from DONE.
        run_gen(16'h1234, 0, 0, "restart");
        push_model(16'h1234);
        check_maze("restart");

        // Reset while carving, then a clean run with the same seed.
        @(negedge clk);
        seed = 16'hBEEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre_rst state_carve", 32'(dbg.state), 32'(ST_CARVE));
        rst = 1'b1;
        #1;
        check("mid_rst busy", 32'(busy), 0);
        check("mid_rst done", 32'(done), 0);
        check_all_ones("mid_rst all_ones");
        check("mid_rst state", 32'(dbg.state), 32'(ST_IDLE));
        @(negedge clk); rst = 1'b0;
        run_gen(16'hBEEF, 0, 0, "after_rst");
        push_model(16'hBEEF);
        check_maze("after_rst");
        check_invariants("after_rst");

        // Random seeds.
        for (int k = 0; k < 20; k++) begin
            rs = 16'($urandom_range(0, 65535));
            run_gen(rs, 0, 0, $sformatf("rand%0d", k));
            push_model(rs);
            check_maze($sformatf("rand%0d", k));
            check_invariants($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
